// File: rtl/bram_rd_stream_adapter.sv
// Streams bursts of words from a read-only BRAM port onto a valid/ready stream.
// Reads are credit-limited so every returned word always has room in the output FIFO.
module bram_rd_stream_adapter #(
  parameter int mem_width        = 32,
  parameter int mem_depth        = 4096,
  parameter int read_latency     = 2,
  parameter int simulation_delay = 1,
  localparam int AW = (mem_depth > 1) ? $clog2(mem_depth) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [AW-1:0]        cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 bram_en,
  output logic                 bram_wen,
  output logic [AW-1:0]        bram_addr,
  output logic [mem_width-1:0] bram_din,
  input  logic [mem_width-1:0] bram_dout,
  output logic [mem_width-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready
);

  localparam int FD = read_latency + 2;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(mem_depth - 1);

  if (read_latency < 1 || read_latency > 2 || simulation_delay < 0) begin : g_unsupported_cfg
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    bram_en_q, bram_en_d;
  logic                    bram_last_q, bram_last_d;
  logic [AW-1:0]           bram_addr_q, bram_addr_d;
  logic [AW-1:0]           rem_q, rem_d;
  logic [read_latency-1:0] vpipe_q, vpipe_d;
  logic [read_latency-1:0] lpipe_q, lpipe_d;
  logic [mem_width:0]      fifo_q [FD];
  logic [mem_width:0]      fifo_d [FD];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d, cred_q, cred_d;
  logic                    push_s, pop_s, issue_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign bram_en   = bram_en_q;
  assign bram_wen  = 1'b0;
  assign bram_addr = bram_addr_q;
  assign bram_din  = {mem_width{1'b0}};
  assign m_valid   = (cnt_q != CW'(0));
  assign m_data    = fifo_q[rd_ptr_q][mem_width-1:0];
  assign m_last    = m_valid && fifo_q[rd_ptr_q][mem_width];

  // FIFO strobes and read credit; a pop this cycle frees credit for the next issue
  always_comb begin
    pop_s      = m_valid && m_ready;
    push_s     = vpipe_q[read_latency-1];
    issue_ok_s = (cred_q - CW'(pop_s)) < CW'(FD);
  end

  // Burst sequencing: next state and next read request
  always_comb begin
    state_d     = state_q;
    bram_en_d   = 1'b0;
    bram_last_d = 1'b0;
    bram_addr_d = bram_addr_q;
    rem_d       = rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = RUN;
          bram_en_d   = 1'b1;
          bram_addr_d = cmd_addr;
          rem_d       = cmd_len;
          bram_last_d = (cmd_len == AW'(0));
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rem_q == AW'(0)) begin
          state_d = DRAIN;
        end else if (issue_ok_s) begin
          bram_en_d   = 1'b1;
          bram_addr_d = (bram_addr_q == ADDR_MAX) ? AW'(0) : bram_addr_q + AW'(1);
          rem_d       = rem_q - AW'(1);
          bram_last_d = (rem_q == AW'(1));
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && m_last) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return-data tracking pipe, FIFO storage/pointers and credit accounting
  always_comb begin
    vpipe_d[0] = bram_en_q;
    lpipe_d[0] = bram_last_q;
    for (int i = 1; i < read_latency; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      lpipe_d[i] = lpipe_q[i-1];
    end
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = {lpipe_q[read_latency-1], bram_dout};
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);
    cred_d = cred_q + CW'(bram_en_d) - CW'(pop_s);
  end

  // State and datapath registers; reset also flushes reads still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bram_en_q   <= 1'b0;
      bram_last_q <= 1'b0;
      bram_addr_q <= AW'(0);
      rem_q       <= AW'(0);
      vpipe_q     <= {read_latency{1'b0}};
      lpipe_q     <= {read_latency{1'b0}};
      for (int i = 0; i < FD; i++) fifo_q[i] <= {(mem_width + 1){1'b0}};
      wr_ptr_q    <= PW'(0);
      rd_ptr_q    <= PW'(0);
      cnt_q       <= CW'(0);
      cred_q      <= CW'(0);
    end else begin
      state_q     <= state_d;
      bram_en_q   <= bram_en_d;
      bram_last_q <= bram_last_d;
      bram_addr_q <= bram_addr_d;
      rem_q       <= rem_d;
      vpipe_q     <= vpipe_d;
      lpipe_q     <= lpipe_d;
      for (int i = 0; i < FD; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cred_q      <= cred_d;
    end
  end

endmodule

// File: tb/tb_bram_rd_stream_adapter.sv
// Bench for bram_rd_stream_adapter: a latency-1 and a latency-2 instance share the command
// and stream-ready inputs; each has its own BRAM model (word value = address) and scoreboard.
module tb_bram_rd_stream_adapter;

  localparam int W     = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          cmd_valid;
  logic          m_ready;

  logic          cmd_ready [2];
  logic          bram_en   [2];
  logic          bram_wen  [2];
  logic [AW-1:0] bram_addr [2];
  logic [W-1:0]  bram_din  [2];
  logic [W-1:0]  bram_dout [2];
  logic [W-1:0]  m_data    [2];
  logic          m_valid   [2];
  logic          m_last    [2];

  logic [W-1:0]  l2_stage;

  int   vectors;
  int   miscompares;
  bit   rnd_mode;

  int   iss_addr [2];
  int   iss_left [2];
  int   out_addr [2];
  int   out_left [2];
  int   issued   [2];
  int   popped   [2];
  int   beats_total [2];
  logic         held_v [2];
  logic [W-1:0] held_d [2];
  logic         held_l [2];

  bram_rd_stream_adapter #(.mem_width(W), .mem_depth(DEPTH), .read_latency(1), .simulation_delay(1)) dut_l1 (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready[0]), .bram_en(bram_en[0]), .bram_wen(bram_wen[0]), .bram_addr(bram_addr[0]),
    .bram_din(bram_din[0]), .bram_dout(bram_dout[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_last(m_last[0]), .m_ready(m_ready)
  );

  bram_rd_stream_adapter #(.mem_width(W), .mem_depth(DEPTH), .read_latency(2), .simulation_delay(1)) dut_l2 (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready[1]), .bram_en(bram_en[1]), .bram_wen(bram_wen[1]), .bram_addr(bram_addr[1]),
    .bram_din(bram_din[1]), .bram_dout(bram_dout[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_last(m_last[1]), .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: each word holds its own address
  always @(posedge clk) begin
    if (bram_en[0]) bram_dout[0] <= W'(bram_addr[0]);
    if (bram_en[1]) l2_stage <= W'(bram_addr[1]);
    bram_dout[1] <= l2_stage;
  end

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Scoreboard: expected issue/beat sequence follows directly from each accepted command
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        iss_left[i] <= 0;
        out_left[i] <= 0;
        issued[i]   <= 0;
        popped[i]   <= 0;
        held_v[i]   <= 1'b0;
      end else begin
        if (cmd_valid && cmd_ready[i]) begin
          iss_addr[i] <= int'(cmd_addr);
          iss_left[i] <= int'(cmd_len) + 1;
          out_addr[i] <= int'(cmd_addr);
          out_left[i] <= int'(cmd_len) + 1;
          issued[i]   <= 0;
          popped[i]   <= 0;
        end
        if (bram_en[i]) begin
          check("issue_allowed", i, 64'(iss_left[i] > 0), 64'(1));
          check("bram_addr", i, 64'(bram_addr[i]), 64'(iss_addr[i]));
          check("bram_wen_din", i, 64'({bram_wen[i], bram_din[i]}), 64'(0));
          check("credit_limit", i, 64'((issued[i] + 1 - popped[i]) <= (i + 3)), 64'(1));
          issued[i]   <= issued[i] + 1;
          iss_addr[i] <= (iss_addr[i] + 1) % DEPTH;
          iss_left[i] <= iss_left[i] - 1;
        end
        if (held_v[i]) begin
          check("stall_valid", i, 64'(m_valid[i]), 64'(1));
          check("stall_data", i, 64'(m_data[i]), 64'(held_d[i]));
          check("stall_last", i, 64'(m_last[i]), 64'(held_l[i]));
        end
        if (!m_valid[i]) begin
          check("last_when_idle", i, 64'(m_last[i]), 64'(0));
        end else if (out_left[i] == 0) begin
          check("spurious_beat", i, 64'(m_valid[i]), 64'(0));
        end else if (m_ready) begin
          check("m_data", i, 64'(m_data[i]), 64'(out_addr[i]));
          check("m_last", i, 64'(m_last[i]), 64'(out_left[i] == 1));
          out_addr[i]    <= (out_addr[i] + 1) % DEPTH;
          out_left[i]    <= out_left[i] - 1;
          popped[i]      <= popped[i] + 1;
          beats_total[i] <= beats_total[i] + 1;
        end
        held_v[i] <= m_valid[i] && !m_ready;
        held_d[i] <= m_data[i];
        held_l[i] <= m_last[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 0, 64'(cmd_ready[0] && cmd_ready[1]), 64'(1));
  endtask

  task automatic send(input int a, input int l);
    tick();
    wait_idle(6000);
    cmd_addr  = AW'(a);
    cmd_len   = AW'(l);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check("rst_cmd_ready", i, 64'(cmd_ready[i]), 64'(1));
      check("rst_bram_en", i, 64'(bram_en[i]), 64'(0));
      check("rst_bram_addr", i, 64'(bram_addr[i]), 64'(0));
      check("rst_m_valid", i, 64'(m_valid[i]), 64'(0));
      check("rst_m_last", i, 64'(m_last[i]), 64'(0));
      check("rst_m_data", i, 64'(m_data[i]), 64'(0));
    end
  endtask

  task automatic check_delivered();
    for (int i = 0; i < 2; i++) check("beats_outstanding", i, 64'(out_left[i]), 64'(0));
  endtask

  initial begin
    logic [W-1:0] got [8];
    int n;
    int cnt [2];
    int base [2];
    int a;
    vectors     = 0;
    miscompares = 0;
    rnd_mode    = 1'b0;
    beats_total = '{0, 0};
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = AW'(0);
    cmd_len     = AW'(0);
    m_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;

    // burst of 4 from address 10; exact cycle positions relative to the handshake
    send(10, 3);
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      check("a_en_l2", rel, 64'(bram_en[1]), 64'(rel <= 4));
      check("a_valid_l2", rel, 64'(m_valid[1]), 64'(rel >= 4 && rel <= 7));
      check("a_valid_l1", rel, 64'(m_valid[0]), 64'(rel >= 3 && rel <= 6));
      if (rel >= 4 && rel <= 7) begin
        check("a_data_l2", rel, 64'(m_data[1]), 64'(10 + rel - 4));
        check("a_last_l2", rel, 64'(m_last[1]), 64'(rel == 7));
      end
      if (rel >= 3 && rel <= 6) check("a_data_l1", rel, 64'(m_data[0]), 64'(10 + rel - 3));
      check("a_cmd_ready_l2", rel, 64'(cmd_ready[1]), 64'(rel == 8));
    end

    // single-word burst
    send(5, 0);
    for (int rel = 1; rel <= 4; rel++) begin
      @(negedge clk);
      check("b_en_l1", rel, 64'(bram_en[0]), 64'(rel == 1));
      check("b_valid_l1", rel, 64'(m_valid[0]), 64'(rel == 3));
      check("b_valid_l2", rel, 64'(m_valid[1]), 64'(rel == 4));
      if (rel == 3) begin
        check("b_data_l1", rel, 64'(m_data[0]), 64'(5));
        check("b_last_l1", rel, 64'(m_last[0]), 64'(1));
      end
    end

    // address wrap at the top of memory
    send(4094, 3);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_valid[1] && m_ready && n < 8) begin
        got[n] = m_data[1];
        n++;
      end
    end
    check("c_beats", 1, 64'(n), 64'(4));
    check("c_d0", 1, 64'(got[0]), 64'(4094));
    check("c_d1", 1, 64'(got[1]), 64'(4095));
    check("c_d2", 1, 64'(got[2]), 64'(0));
    check("c_d3", 1, 64'(got[3]), 64'(1));

    // stalled stream: issue stops at the FIFO depth, then everything drains
    tick();
    m_ready = 1'b0;
    send(200, 15);
    cnt = '{0, 0};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (bram_en[i]) cnt[i]++;
    end
    check("d_issues_l1", 0, 64'(cnt[0]), 64'(3));
    check("d_issues_l2", 1, 64'(cnt[1]), 64'(4));
    tick();
    m_ready = 1'b1;
    wait_idle(200);
    check_delivered();

    // random backpressure
    tick();
    rnd_mode = 1'b1;
    send(77, 31);
    wait_idle(500);
    check_delivered();
    for (int k = 0; k < 24; k++) begin
      a = (k % 4 == 0) ? DEPTH - 1 - int'($urandom_range(0, 5)) : int'($urandom_range(0, DEPTH - 1));
      send(a, int'($urandom_range(0, 40)));
      wait_idle(600);
    end
    check_delivered();

    // reset mid-burst with reads in flight, then a clean 2-word burst
    rnd_mode = 1'b0;
    tick();
    m_ready = 1'b1;
    send(300, 10);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    tick();
    tick();
    rst = 1'b0;
    send(0, 1);
    n = 0;
    cnt = '{0, 0};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid[0] && m_ready) cnt[0]++;
      if (m_valid[1] && m_ready && n < 8) begin
        got[n] = m_data[1];
        n++;
      end
    end
    check("f_beats_l2", 1, 64'(n), 64'(2));
    check("f_beats_l1", 0, 64'(cnt[0]), 64'(2));
    check("f_d0", 1, 64'(got[0]), 64'(0));
    check("f_d1", 1, 64'(got[1]), 64'(1));

    // full-memory burst from a nonzero address
    tick();
    base[0] = beats_total[0];
    base[1] = beats_total[1];
    send(100, DEPTH - 1);
    wait_idle(4400);
    tick();
    for (int i = 0; i < 2; i++) check("g_beats", i, 64'(beats_total[i] - base[i]), 64'(DEPTH));
    check_delivered();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
